// File: rtl/map_writer.sv
// Map RAM writer: clears the whole map or fills a clipped rectangle,
// one pixel per cycle in row-major order, with registered write outputs.
`timescale 1ns/1ps
module map_writer #(
  parameter int unsigned MAP_COLS    = 256,
  parameter int unsigned MAP_ROWS    = 128,
  parameter logic [3:0]  CLEAR_COLOR = 4'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_start,
  input  logic        rect_valid,
  output logic        rect_ready,
  input  logic [8:0]  rect_x,
  input  logic [6:0]  rect_y,
  input  logic [8:0]  rect_w,
  input  logic [6:0]  rect_h,
  input  logic [3:0]  rect_color,
  output logic        wr_en,
  output logic [15:0] wr_adr,
  output logic [3:0]  wr_data,
  output logic        busy,
  output logic        done
);

  // Walk counters are one bit wider than the ports so x+w and y+h never wrap.
  localparam int unsigned CW  = 10;
  localparam int unsigned RW  = 8;
  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_FILL  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   x0_q, x0_d;
  logic [CW-1:0]   x_end_q, x_end_d;
  logic [RW-1:0]   y_end_q, y_end_d;
  logic [DW-1:0]   color_q, color_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_adr_q, wr_adr_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic            done_q, done_d;

  logic [CW-1:0]   col_inc;
  logic [RW-1:0]   row_inc;
  logic            last_col;
  logic            last_row;
  logic            vis_en;
  logic [CW-1:0]   vis_col;
  logic [RW-1:0]   vis_row;
  logic [DW-1:0]   vis_color;
  logic            rect_empty;

  assign col_inc    = col_q + CW'(1);
  assign row_inc    = row_q + RW'(1);
  assign last_col   = (col_inc == x_end_q);
  assign last_row   = (row_inc == y_end_q);
  assign rect_empty = (rect_w == 9'd0) || (rect_h == 7'd0);

  // Next-state: pick the pixel visited on this edge, then decide whether it is written.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    x0_d      = x0_q;
    x_end_d   = x_end_q;
    y_end_d   = y_end_q;
    color_d   = color_q;
    wr_en_d   = 1'b0;
    wr_adr_d  = wr_adr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    vis_en    = 1'b0;
    vis_col   = col_q;
    vis_row   = row_q;
    vis_color = color_q;

    case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          state_d   = ST_CLEAR;
          x0_d      = '0;
          x_end_d   = CW'(MAP_COLS);
          y_end_d   = RW'(MAP_ROWS);
          color_d   = CLEAR_COLOR;
          vis_en    = 1'b1;
          vis_col   = '0;
          vis_row   = '0;
          vis_color = CLEAR_COLOR;
        end else if (rect_valid) begin
          if (rect_empty) begin
            done_d = 1'b1;
          end else begin
            state_d   = ST_FILL;
            x0_d      = CW'(rect_x);
            x_end_d   = CW'(rect_x) + CW'(rect_w);
            y_end_d   = RW'(rect_y) + RW'(rect_h);
            color_d   = rect_color;
            vis_en    = 1'b1;
            vis_col   = CW'(rect_x);
            vis_row   = RW'(rect_y);
            vis_color = rect_color;
          end
        end
      end
      ST_CLEAR, ST_FILL: begin
        if (last_col && last_row) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          vis_en = 1'b1;
          if (last_col) begin
            vis_col = x0_q;
            vis_row = row_inc;
          end else begin
            vis_col = col_inc;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Off-map visits still take their cycle but leave the RAM port untouched.
    if (vis_en) begin
      col_d = vis_col;
      row_d = vis_row;
      if ((vis_col < CW'(MAP_COLS)) && (vis_row < RW'(MAP_ROWS))) begin
        wr_en_d   = 1'b1;
        wr_adr_d  = {vis_row[6:0], vis_col[8:0]};
        wr_data_d = vis_color;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      x0_q      <= '0;
      x_end_q   <= '0;
      y_end_q   <= '0;
      color_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_adr_q  <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      x0_q      <= x0_d;
      x_end_q   <= x_end_d;
      y_end_q   <= y_end_d;
      color_q   <= color_d;
      wr_en_q   <= wr_en_d;
      wr_adr_q  <= wr_adr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  assign rect_ready = (state_q == ST_IDLE) && !clear_start;
  assign busy       = (state_q != ST_IDLE);
  assign wr_en      = wr_en_q;
  assign wr_adr     = wr_adr_q;
  assign wr_data    = wr_data_q;
  assign done       = done_q;

endmodule

// File: tb/tb_map_writer.sv
// Bench for map_writer: a small-map and a default-map instance, each checked
// every cycle against an index-arithmetic model, plus literal scenario checks.
`timescale 1ns/1ps
module tb_map_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst, clear_start, rect_valid, rect_ready, wr_en, busy, done;
  logic [1:0][8:0]  rect_x, rect_w;
  logic [1:0][6:0]  rect_y, rect_h;
  logic [1:0][3:0]  rect_color, wr_data;
  logic [1:0][15:0] wr_adr;

  map_writer #(.MAP_COLS(8), .MAP_ROWS(4), .CLEAR_COLOR(4'h1)) dut_s (
    .clk(clk), .rst(rst[0]), .clear_start(clear_start[0]), .rect_valid(rect_valid[0]),
    .rect_ready(rect_ready[0]), .rect_x(rect_x[0]), .rect_y(rect_y[0]), .rect_w(rect_w[0]),
    .rect_h(rect_h[0]), .rect_color(rect_color[0]), .wr_en(wr_en[0]), .wr_adr(wr_adr[0]),
    .wr_data(wr_data[0]), .busy(busy[0]), .done(done[0]));

  map_writer dut_d (
    .clk(clk), .rst(rst[1]), .clear_start(clear_start[1]), .rect_valid(rect_valid[1]),
    .rect_ready(rect_ready[1]), .rect_x(rect_x[1]), .rect_y(rect_y[1]), .rect_w(rect_w[1]),
    .rect_h(rect_h[1]), .rect_color(rect_color[1]), .wr_en(wr_en[1]), .wr_adr(wr_adr[1]),
    .wr_data(wr_data[1]), .busy(busy[1]), .done(done[1]));

  function automatic int cols_of(input int i);
    return (i == 0) ? 8 : 256;
  endfunction
  function automatic int rows_of(input int i);
    return (i == 0) ? 4 : 128;
  endfunction

  // Model: an active request is a pixel index k in 0..n-1 over a w-wide rectangle.
  bit         m_act [2];
  int         m_k [2], m_n [2], m_x [2], m_y [2], m_w [2];
  logic [3:0] m_color [2];
  logic       e_wr_en [2], e_done [2], e_busy [2];
  logic [15:0] e_adr [2];
  logic [3:0] e_data [2];

  int n_vec = 0, n_bad = 0, cyc = 0;
  bit chk_en = 1'b0;
  logic [19:0] wlog0 [$];
  logic [19:0] wlog1 [$];
  int done_cnt [2], done_cyc [2], last_wr_cyc [2];

  logic [15:0] exp33 [6] = '{16'h0A0A, 16'h0A0B, 16'h0A0C, 16'h0C0A, 16'h0C0B, 16'h0C0C};

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d cyc=%0d got=%0h want=%0h", name, i, cyc, act, exp);
    end
  endtask

  task automatic model_step(input int i);
    int col, row;
    if (rst[i]) begin
      m_act[i] = 1'b0;
      e_wr_en[i] = 1'b0; e_done[i] = 1'b0; e_busy[i] = 1'b0;
      e_adr[i] = 16'h0000; e_data[i] = 4'h0;
    end else begin
      if (!m_act[i]) begin
        e_wr_en[i] = 1'b0; e_done[i] = 1'b0; e_busy[i] = 1'b0;
        if (clear_start[i]) begin
          m_act[i] = 1'b1; m_k[i] = 0; m_x[i] = 0; m_y[i] = 0;
          m_w[i] = cols_of(i); m_n[i] = cols_of(i) * rows_of(i); m_color[i] = 4'h1;
        end else if (rect_valid[i]) begin
          m_act[i] = 1'b1; m_k[i] = 0;
          m_x[i] = int'(rect_x[i]); m_y[i] = int'(rect_y[i]); m_w[i] = int'(rect_w[i]);
          m_n[i] = int'(rect_w[i]) * int'(rect_h[i]); m_color[i] = rect_color[i];
        end
      end
      if (m_act[i]) begin
        if (m_k[i] < m_n[i]) begin
          col = m_x[i] + m_k[i] % m_w[i];
          row = m_y[i] + m_k[i] / m_w[i];
          e_busy[i] = 1'b1; e_done[i] = 1'b0;
          if (col < cols_of(i) && row < rows_of(i)) begin
            e_wr_en[i] = 1'b1; e_adr[i] = 16'(row * 512 + col); e_data[i] = m_color[i];
          end else begin
            e_wr_en[i] = 1'b0;
          end
          m_k[i]++;
        end else begin
          m_act[i] = 1'b0;
          e_busy[i] = 1'b0; e_done[i] = 1'b1; e_wr_en[i] = 1'b0;
        end
      end
    end
  endtask

  // Compare process: every cycle, both instances, on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (chk_en) begin
        for (int i = 0; i < 2; i++) begin
          chk("wr_en", i, 32'(wr_en[i]), 32'(e_wr_en[i]));
          chk("wr_adr", i, 32'(wr_adr[i]), 32'(e_adr[i]));
          chk("wr_data", i, 32'(wr_data[i]), 32'(e_data[i]));
          chk("done", i, 32'(done[i]), 32'(e_done[i]));
          chk("busy", i, 32'(busy[i]), 32'(e_busy[i]));
          chk("rect_ready", i, 32'(rect_ready[i]), 32'(!e_busy[i] && !clear_start[i]));
          if (wr_en[i] === 1'b1) begin
            if (i == 0) wlog0.push_back({wr_data[i], wr_adr[i]});
            else        wlog1.push_back({wr_data[i], wr_adr[i]});
            last_wr_cyc[i] = cyc;
          end
          if (done[i] === 1'b1) begin
            done_cnt[i]++;
            done_cyc[i] = cyc;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
    #1;
  endtask

  task automatic quiet(input int i);
    rst[i] = 1'b0; clear_start[i] = 1'b0; rect_valid[i] = 1'b0;
  endtask

  task automatic set_rect(input int i, input int x, input int y, input int w, input int h, input int c);
    rect_x[i] = 9'(x); rect_y[i] = 7'(y); rect_w[i] = 9'(w); rect_h[i] = 7'(h);
    rect_color[i] = 4'(c); rect_valid[i] = 1'b1;
  endtask

  task automatic clr_log(input int i);
    if (i == 0) wlog0.delete(); else wlog1.delete();
    done_cnt[i] = 0; done_cyc[i] = -1; last_wr_cyc[i] = -1;
  endtask

  function automatic int log_size(input int i);
    return (i == 0) ? wlog0.size() : wlog1.size();
  endfunction

  function automatic logic [19:0] log_at(input int i, input int k);
    if (k >= log_size(i)) return 20'hFFFFF;
    return (i == 0) ? wlog0[k] : wlog1[k];
  endfunction

  task automatic wait_idle(input int i, input int budget);
    int n;
    n = 0;
    while (m_act[i] && n < budget) begin
      tick();
      n++;
    end
    if (m_act[i]) chk("idle_timeout", i, 32'(m_act[i]), 32'd0);
    @(negedge clk); #1;
  endtask

  initial begin
    int t0;
    for (int i = 0; i < 2; i++) begin
      quiet(i);
      set_rect(i, 0, 0, 0, 0, 0);
      rect_valid[i] = 1'b0;
      rst[i] = 1'b1;
      done_cnt[i] = 0; done_cyc[i] = -1; last_wr_cyc[i] = -1;
    end

    // Reset values.
    tick();
    chk_en = 1'b1;
    tick();
    @(negedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_wr_en", i, 32'(wr_en[i]), 32'd0);
      chk("rst_wr_adr", i, 32'(wr_adr[i]), 32'h0000);
      chk("rst_wr_data", i, 32'(wr_data[i]), 32'h0);
      chk("rst_done", i, 32'(done[i]), 32'd0);
      chk("rst_busy", i, 32'(busy[i]), 32'd0);
      chk("rst_ready", i, 32'(rect_ready[i]), 32'd1);
      quiet(i);
    end
    tick();

    // Full clear of the 8x4 map.
    clr_log(0);
    clear_start[0] = 1'b1;
    tick();
    clear_start[0] = 1'b0;
    @(negedge clk); #1;
    chk("clr_first_wr", 0, 32'(wr_en[0]), 32'd1);
    chk("clr_first_adr", 0, 32'(wr_adr[0]), 32'h0000);
    wait_idle(0, 100);
    chk("clr_count", 0, 32'(log_size(0)), 32'd32);
    for (int k = 0; k < 32; k++)
      chk("clr_seq", 0, 32'(log_at(0, k)), 32'(20'h10000 | ((k / 8) << 9) | (k % 8)));
    chk("clr_done_cnt", 0, 32'(done_cnt[0]), 32'd1);
    chk("clr_done_pos", 0, 32'(done_cyc[0]), 32'(last_wr_cyc[0] + 1));

    // Small rectangle on the default map.
    clr_log(1);
    set_rect(1, 10, 5, 3, 2, 7);
    tick();
    quiet(1);
    @(negedge clk); #1;
    chk("r33_latency", 1, 32'(wr_en[1]), 32'd1);
    wait_idle(1, 20);
    chk("r33_count", 1, 32'(log_size(1)), 32'd6);
    for (int k = 0; k < 6; k++)
      chk("r33_seq", 1, 32'(log_at(1, k)), 32'({4'h7, exp33[k]}));
    chk("r33_done_pos", 1, 32'(done_cyc[1]), 32'(last_wr_cyc[1] + 1));

    // Rectangle clipped at the right and bottom edges.
    clr_log(1);
    set_rect(1, 254, 127, 4, 2, 5);
    tick();
    quiet(1);
    @(negedge clk); #1;
    t0 = cyc;
    wait_idle(1, 20);
    chk("r34_count", 1, 32'(log_size(1)), 32'd2);
    chk("r34_w0", 1, 32'(log_at(1, 0)), 32'h5FEFE);
    chk("r34_w1", 1, 32'(log_at(1, 1)), 32'h5FEFF);
    chk("r34_done_pos", 1, 32'(done_cyc[1]), 32'(t0 + 8));

    // Clear wins over a simultaneous rectangle.
    clr_log(0);
    clear_start[0] = 1'b1;
    set_rect(0, 1, 1, 2, 2, 9);
    #1;
    chk("r35_ready_low", 0, 32'(rect_ready[0]), 32'd0);
    tick();
    quiet(0);
    wait_idle(0, 100);
    chk("r35_count", 0, 32'(log_size(0)), 32'd32);
    for (int k = 0; k < 32; k++)
      chk("r35_color", 0, 32'(log_at(0, k) >> 16), 32'h1);

    // Empty rectangle.
    clr_log(1);
    set_rect(1, 3, 3, 0, 5, 2);
    tick();
    quiet(1);
    @(negedge clk); #1;
    chk("r36_done", 1, 32'(done[1]), 32'd1);
    chk("r36_ready", 1, 32'(rect_ready[1]), 32'd1);
    chk("r36_wr_en", 1, 32'(wr_en[1]), 32'd0);
    tick(); tick();
    chk("r36_no_wr", 1, 32'(log_size(1)), 32'd0);
    chk("r36_done_cnt", 1, 32'(done_cnt[1]), 32'd1);

    // Reset in the middle of a fill after two writes.
    clr_log(1);
    set_rect(1, 10, 5, 3, 2, 7);
    tick();
    quiet(1);
    tick();
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    @(negedge clk); #1;
    chk("r37_wr_en", 1, 32'(wr_en[1]), 32'd0);
    chk("r37_adr", 1, 32'(wr_adr[1]), 32'h0000);
    chk("r37_data", 1, 32'(wr_data[1]), 32'h0);
    chk("r37_ready", 1, 32'(rect_ready[1]), 32'd1);
    for (int k = 0; k < 8; k++) tick();
    @(negedge clk); #1;
    chk("r37_count", 1, 32'(log_size(1)), 32'd2);
    chk("r37_no_done", 1, 32'(done_cnt[1]), 32'd0);

    // Wide rectangle entirely past the last column: end arithmetic must not wrap.
    clr_log(1);
    set_rect(1, 500, 0, 511, 1, 3);
    tick();
    quiet(1);
    wait_idle(1, 600);
    chk("wide_no_wr", 1, 32'(log_size(1)), 32'd0);
    chk("wide_done", 1, 32'(done_cnt[1]), 32'd1);

    // Randomized traffic on both instances, including requests while busy.
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 2; i++) begin
        rst[i] = ($urandom_range(0, 299) == 0);
        clear_start[i] = (i == 0) && ($urandom_range(0, 39) == 0);
        rect_valid[i] = ($urandom_range(0, 2) == 0);
        rect_color[i] = 4'($urandom_range(0, 15));
        if (i == 0) begin
          if ($urandom_range(0, 19) == 0) begin
            rect_x[i] = 9'($urandom_range(0, 511)); rect_y[i] = 7'($urandom_range(0, 127));
            rect_w[i] = 9'($urandom_range(256, 511)); rect_h[i] = 7'($urandom_range(1, 2));
          end else begin
            rect_x[i] = 9'($urandom_range(0, 12)); rect_y[i] = 7'($urandom_range(0, 6));
            rect_w[i] = 9'($urandom_range(0, 10)); rect_h[i] = 7'($urandom_range(0, 5));
          end
        end else begin
          rect_x[i] = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(230, 255));
          rect_y[i] = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(118, 127));
          rect_w[i] = 9'($urandom_range(0, 30)); rect_h[i] = 7'($urandom_range(0, 6));
        end
      end
      tick();
    end

    for (int i = 0; i < 2; i++) quiet(i);
    for (int k = 0; k < 4; k++) tick();
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/map_writer.md
MAP_WRITER -- requirements
Module: map_writer

Interface
REQ-001 Parameter MAP_COLS, default 256, number of map columns (1..512) SHALL be honoured.
REQ-002 Parameter MAP_ROWS, default 128, number of map rows (1..128) SHALL be honoured.
REQ-003 Parameter CLEAR_COLOR, default 4'h1, pixel value written by a clear SHALL be honoured.
REQ-004 clk  input  1  clock; all state SHALL change on its rising edge only.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 clear_start  input  1  single-cycle request to clear the whole map.
REQ-007 rect_valid  input  1  rectangle fill request valid.
REQ-008 rect_ready  output  1  block can accept a rectangle this cycle.
REQ-009 rect_x  input  9, rect_y  input  7  top-left column/row of rectangle.
REQ-010 rect_w  input  9, rect_h  input  7  rectangle width/height in pixels.
REQ-011 rect_color  input  4  pixel value for the rectangle.
REQ-012 wr_en  output  1  map RAM write strobe, one pixel per cycle.
REQ-013 wr_adr  output  16  map RAM address: [15:9] row, [8:0] column.
REQ-014 wr_data  output  4  map RAM write data.
REQ-015 busy  output  1  high while in CLEAR or FILL.
REQ-016 done  output  1  one-cycle pulse when a clear or fill finishes.

Function
REQ-017 FSM states: IDLE, CLEAR, FILL; wr_en, wr_adr, wr_data, done SHALL be registered outputs.
REQ-018 rect_ready SHALL be high only in IDLE with clear_start low.
REQ-019 IDLE + clear_start -> CLEAR; clear_start SHALL win over a simultaneous rect_valid (rect not accepted).
REQ-020 IDLE + rect_valid & rect_ready -> FILL; rect_x/y/w/h/color SHALL be captured on that edge.
REQ-021 clear_start and rect_valid SHALL be ignored while busy; no queuing.
REQ-022 First write SHALL appear in the cycle after the accepting edge (latency 1).
REQ-023 CLEAR SHALL write CLEAR_COLOR row-major, column fastest, from (0,0) to (MAP_COLS-1,MAP_ROWS-1), wr_en high every cycle, exactly MAP_COLS*MAP_ROWS writes.
REQ-024 FILL SHALL visit row-major, column fastest, columns rect_x..rect_x+rect_w-1, rows rect_y..rect_y+rect_h-1, one visit per cycle, rect_w*rect_h cycles.
REQ-025 Visited pixels with column >= MAP_COLS or row >= MAP_ROWS SHALL be clipped: wr_en low that cycle, visit still consumes the cycle.
REQ-026 End-of-rectangle comparisons SHALL use 10-bit column and 8-bit row arithmetic so rect_x+rect_w and rect_y+rect_h never wrap.
REQ-027 rect_w==0 or rect_h==0 SHALL perform no writes, done pulse one cycle after acceptance, return to IDLE.
REQ-028 done SHALL pulse in the cycle after the last visit; FSM SHALL be in IDLE (rect_ready high) in that same cycle.
REQ-029 wr_adr and wr_data SHALL hold their last values while wr_en is low; only wr_en qualifies them.

Reset
REQ-030 rst SHALL force IDLE, wr_en=0, wr_adr=16'h0000, wr_data=4'h0, done=0, busy=0, rect_ready=1 on the next edge.
REQ-031 rst during CLEAR or FILL SHALL abort: no further wr_en, no done pulse, captured request discarded.

Verification
REQ-032 MAP_COLS=8, MAP_ROWS=4, clear_start pulse -> 32 consecutive wr_en, wr_adr 0x0000..0x0007, 0x0200..0x0207, ..., 0x0607, wr_data 4'h1, done one cycle after 0x0607.
REQ-033 rect x=10,y=5,w=3,h=2,color=7 -> wr_adr 0x0A0A,0x0A0B,0x0A0C,0x0C0A,0x0C0B,0x0C0C, wr_data 4'h7, first write 1 cycle after handshake, then done.
REQ-034 Default params, rect x=254,y=127,w=4,h=2 -> 8 visit cycles, writes only at 0xFEFE,0xFEFF, wr_en low for the 6 clipped visits, done after 8th cycle.
REQ-035 clear_start and rect_valid high in same IDLE cycle -> CLEAR runs, rect_ready low that cycle, rectangle not written.
REQ-036 rect w=0,h=5 accepted -> no wr_en, done pulse 1 cycle after acceptance, rect_ready high same cycle.
REQ-037 rst asserted mid-FILL after 2 writes -> wr_en 0 from next edge, no done, outputs at reset values, rect_ready high.
